uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity.
//   CLK        oversampling clock, rising edge
//   RST        asynchronous active-low reset
//   RX_IN      serial line (idles high), asynchronous to CLK
//   PAR_EN     1 = parity bit follows the data bits
//   PAR_TYP    0 = even parity, 1 = odd parity
//   Prescale   CLK cycles per bit (8, 16 or 32)
//   P_DATA     last frame received without error
//   data_valid one-cycle pulse when P_DATA updates
//   par_err    one-cycle pulse on a parity failure
//   stp_err    one-cycle pulse on a bad stop bit
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int unsigned BW = $clog2(DATA_WIDTH + 3);

  state_t                state_q, state_d;
  logic                  rx_meta_q, rx_meta_d;
  logic                  rx_s_q, rx_s_d;
  logic [5:0]            edge_q, edge_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [5:0]            presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [2:0]            samp_q, samp_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;

  logic [5:0] half;
  logic [5:0] last;
  logic       wrap;
  logic       maj;
  logic       par_exp;

  always_comb begin
    half    = {1'b0, presc_q[5:1]};
    last    = presc_q - 6'd1;
    wrap    = (edge_q == last);
    maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    par_exp = par_typ_q ? ~^shift_q : ^shift_q;

    rx_meta_d = RX_IN;
    rx_s_d    = rx_meta_q;
    state_d   = state_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    samp_d    = samp_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    p_data_d  = p_data_q;
    dv_d      = 1'b0;
    pe_d      = 1'b0;
    se_d      = 1'b0;

    if (state_q != IDLE) begin
      edge_d = wrap ? '0 : edge_q + 6'd1;
      if (wrap) bit_d = bit_q + BW'(1);
      if (edge_q == half - 6'd1) samp_d[0] = rx_s_q;
      if (edge_q == half)        samp_d[1] = rx_s_q;
      if (edge_q == half + 6'd1) samp_d[2] = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_s_q) begin
          // This cycle is edge count 0 of the start bit.
          state_d   = START;
          edge_d    = 6'd1;
          presc_d   = Prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (edge_q == half + 6'd2 && maj) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (wrap) begin
          shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BW'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (wrap) begin
          par_bad_d = (maj != par_exp);
          state_d   = STOP;
        end
      end
      STOP: begin
        // Outputs are registered, so decide one count early to land on P-1.
        if (edge_q == last - 6'd1) begin
          if (par_bad_q || !maj) begin
            pe_d = par_bad_q;
            se_d = ~maj;
          end else begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
        if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      edge_q    <= '0;
      bit_q     <= '0;
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      samp_q    <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      p_data_q  <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      samp_q    <= samp_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      p_data_q  <= p_data_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      se_q      <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (DATA_WIDTH = 8).
// Frames are driven one bit period at a time; a negedge monitor logs every
// output pulse with its cycle number, and each frame is checked against a
// table entry or a parity/stop model computed from the frame contents.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] pd;
    int         cyc;
  } ev_t;

  typedef struct {
    int         p;
    bit         pen;
    bit         ptyp;
    logic [7:0] data;
    bit         pbit;
    bit         sbit;
    bit         e_dv;
    bit         e_pe;
    bit         e_se;
    logic [7:0] e_pd;
  } vec_t;

  int         cyc = 0;
  int         tests = 0;
  int         failed = 0;
  int         pd_glitch = 0;
  int         rd = 0;
  logic [7:0] prev_pd = '0;
  ev_t        evq[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Event log, plus a watch on P_DATA changing without data_valid.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (data_valid || par_err || stp_err)
        evq.push_back('{data_valid, par_err, stp_err, P_DATA, cyc});
      if (P_DATA !== prev_pd && data_valid !== 1'b1) pd_glitch <= pd_glitch + 1;
    end
    prev_pd <= P_DATA;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one frame; config is scrambled after the start bit to show it was latched.
  task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                            input bit pbit, input bit sbit, output int st);
    Prescale = p[5:0];
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    st       = cyc;
    RX_IN    = 1'b0;
    repeat (p) tick();
    Prescale = 6'd8 << $urandom_range(0, 2);
    PAR_EN   = 1'($urandom);
    PAR_TYP  = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) tick();
    end
    if (pen) begin
      RX_IN = pbit;
      repeat (p) tick();
    end
    RX_IN = sbit;
    repeat (p) tick();
  endtask

  // Pulse lands 2 synchronizer cycles + (bits*P - 1) after the start drive.
  function automatic int exp_cycle(input int st, input int p, input bit pen);
    return st + 2 + (10 + int'(pen)) * p - 1;
  endfunction

  task automatic check_frame(input string name, input bit e_dv, input bit e_pe, input bit e_se,
                             input logic [7:0] e_pd, input int e_cyc);
    int  n;
    ev_t ev;
    n = evq.size() - rd;
    chk({name, ".count"}, n, (e_dv || e_pe || e_se) ? 1 : 0);
    if (n > 0) begin
      ev = evq[rd];
      chk({name, ".dv"}, ev.dv, e_dv);
      chk({name, ".pe"}, ev.pe, e_pe);
      chk({name, ".se"}, ev.se, e_se);
      chk({name, ".cycle"}, ev.cyc, e_cyc);
      rd = evq.size();
    end
    chk({name, ".P_DATA"}, P_DATA, e_pd);
  endtask

  // Reference parity bit from the count of ones in the payload.
  function automatic bit model_parity(input logic [7:0] d, input bit odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return odd ? bit'((ones + 1) % 2) : bit'(ones % 2);
  endfunction

  vec_t       vecs[7];
  int         st, st2;
  int         p;
  bit         pen, ptyp, pbit, sbit;
  logic [7:0] d;
  logic [7:0] last_good;
  bit         bad_p, bad_s;

  initial begin
    vecs[0] = '{8,  0, 0, 8'hA5, 0, 1, 1, 0, 0, 8'hA5};
    vecs[1] = '{16, 1, 0, 8'h3C, 1, 1, 0, 1, 0, 8'hA5};
    vecs[2] = '{32, 1, 1, 8'h01, 0, 0, 0, 0, 1, 8'hA5};
    vecs[3] = '{16, 1, 1, 8'h7E, 1, 1, 1, 0, 0, 8'h7E};
    vecs[4] = '{32, 0, 0, 8'hC3, 0, 1, 1, 0, 0, 8'hC3};
    vecs[5] = '{8,  1, 0, 8'h80, 0, 0, 0, 1, 1, 8'hC3};
    vecs[6] = '{8,  1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00};

    RST      = 1'b0;
    RX_IN    = 1'b1;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    repeat (3) tick();
    chk("reset.P_DATA", P_DATA, 8'h00);
    chk("reset.data_valid", data_valid, 1'b0);
    chk("reset.par_err", par_err, 1'b0);
    chk("reset.stp_err", stp_err, 1'b0);
    RST = 1'b1;
    idle(5);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].p, vecs[i].pen, vecs[i].ptyp, vecs[i].data, vecs[i].pbit, vecs[i].sbit, st);
      idle(6);
      check_frame($sformatf("vec%0d", i), vecs[i].e_dv, vecs[i].e_pe, vecs[i].e_se,
                  vecs[i].e_pd, exp_cycle(st, vecs[i].p, vecs[i].pen));
    end

    // Start glitch: two low cycles must be rejected, then a real frame follows.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) tick();
    idle(20);
    chk("glitch.count", evq.size() - rd, 0);
    chk("glitch.P_DATA", P_DATA, 8'h00);
    send_frame(8, 0, 0, 8'h5A, 0, 1, st);
    idle(6);
    check_frame("glitch_next", 1, 0, 0, 8'h5A, exp_cycle(st, 8, 0));

    // Back-to-back frames with no idle bit between them.
    send_frame(8, 0, 0, 8'h11, 0, 1, st);
    send_frame(8, 0, 0, 8'hEE, 0, 1, st2);
    idle(6);
    chk("b2b.count", evq.size() - rd, 2);
    if (evq.size() - rd == 2) begin
      chk("b2b.first_pd", evq[rd].pd, 8'h11);
      chk("b2b.first_cycle", evq[rd].cyc, exp_cycle(st, 8, 0));
      chk("b2b.second_pd", evq[rd+1].pd, 8'hEE);
      chk("b2b.second_dv", evq[rd+1].dv, 1'b1);
      chk("b2b.spacing", evq[rd+1].cyc - evq[rd].cyc, 80);
      rd = evq.size();
    end
    chk("b2b.P_DATA", P_DATA, 8'hEE);

    // Reset in the middle of data bit 4 of 0xFF.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) tick();
    RX_IN = 1'b1;
    repeat (4 * 8 + 4) tick();
    RST = 1'b0;
    repeat (3) tick();
    chk("midreset.P_DATA", P_DATA, 8'h00);
    chk("midreset.outputs", {data_valid, par_err, stp_err}, 3'b000);
    RST = 1'b1;
    idle(40);
    chk("midreset.count", evq.size() - rd, 0);
    send_frame(8, 0, 0, 8'h42, 0, 1, st);
    idle(6);
    check_frame("after_reset", 1, 0, 0, 8'h42, exp_cycle(st, 8, 0));

    // Randomized frames against the parity/stop model.
    last_good = 8'h42;
    for (int i = 0; i < 20; i++) begin
      p     = 8 << $urandom_range(0, 2);
      pen   = 1'($urandom);
      ptyp  = 1'($urandom);
      d     = 8'($urandom);
      pbit  = model_parity(d, ptyp) ^ ($urandom_range(0, 3) == 0);
      sbit  = ($urandom_range(0, 4) != 0);
      bad_p = pen && (pbit != model_parity(d, ptyp));
      bad_s = !sbit;
      if (!bad_p && !bad_s) last_good = d;
      send_frame(p, pen, ptyp, d, pbit, sbit, st);
      idle($urandom_range(4, 12));
      check_frame($sformatf("rand%0d", i), !bad_p && !bad_s, bad_p, bad_s, last_good,
                  exp_cycle(st, p, pen));
    end

    chk("P_DATA_stable_between_pulses", pd_glitch, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
